ex_mem_stage_register: RTL and testbench

- Pipeline stage register directly downstream of the scalar/fixed-point ALU pair in the execute stage.
- Captures the ALU result, ALU flags, store data and writeback/memory control, and presents them to the memory stage over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure. The block also holds the architectural NZCV flag register and a saturating backpressure-cycle counter.

---
 rtl/ex_mem_stage_register.sv | 133 +++++++++++++
 tb/tb_ex_mem_stage_register.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_register.sv
// EX/MEM pipeline register with a 2-entry skid buffer, committed NZCV flags
// and a saturating backpressure counter.
module ex_mem_stage_register #(
  parameter int N     = 24,
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     alu_result,
  input  logic [3:0]       alu_flags,
  input  logic [N-1:0]     store_data,
  input  logic [REG_W-1:0] rd,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [N-1:0]     out_store_data,
  output logic [REG_W-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic [3:0]       arch_flags,
  output logic [CNT_W-1:0] stall_cycles
);

  // Entry layout, LSB first: set_flags, mem_to_reg, mem_write, reg_write,
  // rd, flags, store_data, result.
  localparam int RD_LSB    = 4;
  localparam int FLAGS_LSB = RD_LSB + REG_W;
  localparam int SD_LSB    = FLAGS_LSB + 4;
  localparam int RES_LSB   = SD_LSB + N;
  localparam int ENTRY_W   = RES_LSB + N;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [3:0]         arch_flags_q, arch_flags_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               accept;
  logic               transfer;

  assign in_entry = {alu_result, store_data, alu_flags, rd,
                     reg_write, mem_write, mem_to_reg, set_flags};

  // Flush wins over an offered entry; a simultaneous transfer still completes.
  assign accept   = in_valid && in_ready_q && !flush;
  assign transfer = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    arch_flags_d = arch_flags_q;
    stall_d      = stall_q;

    if (transfer && main_q[0]) begin
      arch_flags_d = main_q[FLAGS_LSB +: 4];
    end

    if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (transfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end

    // Registered ready: no combinational path from out_ready to in_ready.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      arch_flags_q <= 4'b0000;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      arch_flags_q <= arch_flags_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid_q;
  assign out_result     = main_q[RES_LSB +: N];
  assign out_store_data = main_q[SD_LSB +: N];
  assign out_rd         = main_q[RD_LSB +: REG_W];
  assign out_reg_write  = main_q[3];
  assign out_mem_write  = main_q[2];
  assign out_mem_to_reg = main_q[1];
  assign arch_flags     = arch_flags_q;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_ex_mem_stage_register.sv
// Self-checking bench for ex_mem_stage_register: scoreboard monitor plus
// table-driven and hand-written sequences.
module tb_ex_mem_stage_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush;
  logic [23:0] alu_result, store_data;
  logic [3:0]  alu_flags, rd;
  logic        reg_write, mem_write, mem_to_reg, set_flags;
  logic        in_ready, out_valid;
  logic [23:0] out_result, out_store_data;
  logic [3:0]  out_rd, arch_flags;
  logic        out_reg_write, out_mem_write, out_mem_to_reg;
  logic [15:0] stall_cycles;

  logic        in_ready4, out_valid4;
  logic [23:0] out_result4, out_store_data4;
  logic [3:0]  out_rd4, arch_flags4;
  logic        out_reg_write4, out_mem_write4, out_mem_to_reg4;
  logic [3:0]  stall_cycles4;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [23:0] res;
    logic [23:0] sd;
    logic [3:0]  fl;
    logic [3:0]  rd;
    logic        rw, mw, m2r, sf;
  } entry_t;

  typedef struct {
    logic        iv;
    logic [23:0] res;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [23:0] ores;
  } row_t;

  entry_t      sb[$];
  logic [3:0]  exp_flags = 4'b0000;
  logic [15:0] exp_stall = 16'd0;

  always #5 clk = ~clk;

  ex_mem_stage_register #(.N(24), .REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .set_flags(set_flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .arch_flags(arch_flags),
    .stall_cycles(stall_cycles)
  );

  ex_mem_stage_register #(.N(24), .REG_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .alu_result(alu_result), .alu_flags(alu_flags), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .set_flags(set_flags), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .out_store_data(out_store_data4), .out_rd(out_rd4),
    .out_reg_write(out_reg_write4), .out_mem_write(out_mem_write4),
    .out_mem_to_reg(out_mem_to_reg4), .arch_flags(arch_flags4),
    .stall_cycles(stall_cycles4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic iv, input logic [23:0] res, input logic [3:0] fl,
                      input logic sf, input logic ordy, input logic fsh);
    @(posedge clk);
    #1;
    in_valid   = iv;
    alu_result = res;
    store_data = res ^ 24'h5A5A5A;
    alu_flags  = fl;
    rd         = res[3:0] ^ 4'hA;
    reg_write  = res[0];
    mem_write  = res[1];
    mem_to_reg = ~res[0];
    set_flags  = sf;
    out_ready  = ordy;
    flush      = fsh;
    @(negedge clk);
  endtask

  // Scoreboard monitor: checks occupancy-derived handshake, flags and stall
  // count every cycle, pops on transfer and pushes on accept.
  always @(negedge clk) begin
    if (mon_en) begin
      int     occ;
      entry_t e;
      occ = sb.size();
      chk("sb_out_valid", 64'(out_valid), 64'(occ != 0));
      chk("sb_in_ready", 64'(in_ready), 64'(occ < 2));
      chk("sb_arch_flags", 64'(arch_flags), 64'(exp_flags));
      chk("sb_stall", 64'(stall_cycles), 64'(exp_stall));
      if (occ != 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_xfer", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          $display("xfer result=0x%06h rd=%0d flags=%b sf=%0d", out_result, out_rd, e.fl, e.sf);
          chk("sb_result", 64'(out_result), 64'(e.res));
          chk("sb_store_data", 64'(out_store_data), 64'(e.sd));
          chk("sb_rd", 64'(out_rd), 64'(e.rd));
          chk("sb_ctrl", 64'({out_reg_write, out_mem_write, out_mem_to_reg}),
              64'({e.rw, e.mw, e.m2r}));
          if (e.sf) exp_flags = e.fl;
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        e.res = alu_result; e.sd = store_data; e.fl = alu_flags; e.rd = rd;
        e.rw = reg_write; e.mw = mem_write; e.m2r = mem_to_reg; e.sf = set_flags;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t        tbl[8];
    logic [15:0] stall0;

    tbl[0] = '{1'b1, 24'h000011, 1'b0, 1'b0, 1'b1, 24'h0};
    tbl[1] = '{1'b1, 24'h000022, 1'b0, 1'b1, 1'b1, 24'h000011};
    tbl[2] = '{1'b1, 24'h000033, 1'b0, 1'b1, 1'b0, 24'h000011};
    tbl[3] = '{1'b1, 24'h000033, 1'b0, 1'b1, 1'b0, 24'h000011};
    tbl[4] = '{1'b1, 24'h000033, 1'b1, 1'b1, 1'b0, 24'h000011};
    tbl[5] = '{1'b1, 24'h000033, 1'b1, 1'b1, 1'b1, 24'h000022};
    tbl[6] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 24'h000033};
    tbl[7] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 24'h0};

    rst = 1'b0;
    in_valid = 0; alu_result = 0; store_data = 0; alu_flags = 0; rd = 0;
    reg_write = 0; mem_write = 0; mem_to_reg = 0; set_flags = 0;
    out_ready = 0; flush = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_arch_flags", 64'(arch_flags), 64'(0));
    chk("rst_stall", 64'(stall_cycles), 64'(0));
    rst = 1'b1;
    mon_en = 1'b1;

    // Streaming at full rate: result k visible the cycle after its accept.
    for (int i = 0; i < 9; i++) begin
      step(i < 8, 24'(i + 1), 4'b0000, 1'b0, 1'b1, 1'b0);
      chk("stream_out_valid", 64'(out_valid), 64'(i > 0));
      chk("stream_in_ready", 64'(in_ready), 64'(1));
      if (i > 0) chk("stream_result", 64'(out_result), 64'(i));
    end
    chk("stream_stall", 64'(stall_cycles), 64'(0));

    // Backpressure A/B/C through the skid buffer.
    stall0 = exp_stall;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].iv, tbl[i].res, 4'b0000, 1'b0, tbl[i].ordy, 1'b0);
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].ov));
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].ir));
      if (tbl[i].ov) chk("tbl_result", 64'(out_result), 64'(tbl[i].ores));
    end
    chk("tbl_stall", 64'(stall_cycles), 64'(stall0 + 16'd3));

    // Flags: set_flags=1 commits, set_flags=0 does not.
    step(1'b1, 24'h000201, 4'b0110, 1'b1, 1'b1, 1'b0);
    step(1'b1, 24'h000202, 4'b1001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("flags_commit", 64'(arch_flags), 64'(4'b0110));
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("flags_hold", 64'(arch_flags), 64'(4'b0110));

    // Flush with both entries valid and a new entry offered.
    step(1'b1, 24'h000101, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'h000102, 4'b0010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'h000077, 4'b1111, 1'b1, 1'b0, 1'b1);
    chk("flush_full", 64'(in_ready), 64'(0));
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    chk("flush_flags", 64'(arch_flags), 64'(4'b0110));
    chk("flush_data_hold", 64'(out_result), 64'(24'h000101));
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("flush_no_capture", 64'(out_valid), 64'(0));

    // Flush concurrent with a transfer: transfer commits, skid discarded.
    step(1'b1, 24'h000301, 4'b1000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'h000302, 4'b0100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("fx_flags", 64'(arch_flags), 64'(4'b1000));
    chk("fx_out_valid", 64'(out_valid), 64'(0));
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("fx_skid_dropped", 64'(arch_flags), 64'(4'b1000));
    chk("fx_still_empty", 64'(out_valid), 64'(0));

    // Asynchronous reset mid-stream, checked before the next rising edge.
    step(1'b1, 24'h000401, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h000402, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #2;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_result", 64'(out_result), 64'(0));
    chk("arst_store_data", 64'(out_store_data), 64'(0));
    chk("arst_rd", 64'(out_rd), 64'(0));
    chk("arst_flags", 64'(arch_flags), 64'(0));
    chk("arst_stall", 64'(stall_cycles), 64'(0));
    chk("arst_stall4", 64'(stall_cycles4), 64'(0));
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    sb.delete();
    exp_flags = 4'b0000;
    exp_stall = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // Saturation of a 4-bit stall counter under a 20-cycle stall.
    step(1'b1, 24'h000501, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("sat_stall4", 64'(stall_cycles4), 64'(15));
    chk("sat_stall16", 64'(stall_cycles), 64'(19));
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("sat_hold4", 64'(stall_cycles4), 64'(15));
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 24'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", 64'(out_valid), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
